// File: rtl/rcu_pll_lock_seq.sv
// PLL power-up sequencer: drives PLL pd/rst pins, qualifies the raw lock, retries, reports failure.
// Latency: raw lock sees a 2-flop synchronizer; lock qualifies LOCK_STABLE_CYC cycles into WAIT_LOCK.
// Backpressure: none; pll_en_i is a level request and dropping it returns to IDLE on the next edge.
module rcu_pll_lock_seq #(
    parameter int PWRUP_CYC       = 16,
    parameter int LOCK_STABLE_CYC = 256,
    parameter int TIMEOUT_CYC     = 4096,
    parameter int MAX_RETRY       = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               pll_en_i,
    input  logic                               pll_raw_lock_i,
    output logic                               pll_pd_o,
    output logic                               pll_rst_o,
    output logic                               pll_lock_o,
    output logic                               pll_fail_o,
    output logic                               lock_lost_o,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt_o,
    output logic [2:0]                         state_o
);

    localparam int RW      = $clog2(MAX_RETRY + 1);
    localparam int CYC_MAX = (PWRUP_CYC > TIMEOUT_CYC) ? PWRUP_CYC : TIMEOUT_CYC;
    localparam int CW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int SW      = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PWRUP     = 3'd1;
    localparam logic [2:0] WAIT_LOCK = 3'd2;
    localparam logic [2:0] LOCKED    = 3'd3;
    localparam logic [2:0] FAIL      = 3'd4;

    localparam logic [CW-1:0] PWRUP_LAST   = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    logic [2:0]    state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cyc_cnt;
    logic [SW-1:0] stable_cnt;
    logic [RW-1:0] retry_cnt;
    logic          lock_lost_q;
    logic          s_lock;

    assign s_lock = sync_q[1];

    // cyc_cnt doubles as the PWRUP dwell counter and the WAIT_LOCK timeout counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            cyc_cnt     <= '0;
            stable_cnt  <= '0;
            retry_cnt   <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], pll_raw_lock_i};
            lock_lost_q <= 1'b0;
            if (!pll_en_i) begin
                state_q    <= IDLE;
                cyc_cnt    <= '0;
                stable_cnt <= '0;
                retry_cnt  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= PWRUP;
                        cyc_cnt <= '0;
                    end
                    PWRUP: begin
                        if (cyc_cnt == PWRUP_LAST) begin
                            state_q    <= WAIT_LOCK;
                            cyc_cnt    <= '0;
                            stable_cnt <= '0;
                        end else begin
                            cyc_cnt <= cyc_cnt + CW'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        cyc_cnt    <= cyc_cnt + CW'(1);
                        stable_cnt <= s_lock ? stable_cnt + SW'(1) : '0;
                        // qualification is checked first so it beats a coincident timeout
                        if (s_lock && (stable_cnt == STABLE_LAST)) begin
                            state_q    <= LOCKED;
                            cyc_cnt    <= '0;
                            stable_cnt <= '0;
                        end else if (cyc_cnt == TIMEOUT_LAST) begin
                            cyc_cnt    <= '0;
                            stable_cnt <= '0;
                            if (retry_cnt < RETRY_MAX) begin
                                retry_cnt <= retry_cnt + RW'(1);
                                state_q   <= PWRUP;
                            end else begin
                                state_q <= FAIL;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!s_lock) begin
                            state_q     <= WAIT_LOCK;
                            cyc_cnt     <= '0;
                            stable_cnt  <= '0;
                            lock_lost_q <= 1'b1;
                        end
                    end
                    FAIL:    state_q <= FAIL;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pll_pd_o    = (state_q == IDLE) || (state_q == FAIL);
    assign pll_rst_o   = (state_q != WAIT_LOCK) && (state_q != LOCKED);
    assign pll_lock_o  = (state_q == LOCKED);
    assign pll_fail_o  = (state_q == FAIL);
    assign lock_lost_o = lock_lost_q;
    assign retry_cnt_o = retry_cnt;
    assign state_o     = state_q;

endmodule

// File: tb/tb_rcu_pll_lock_seq.sv
// Bench for rcu_pll_lock_seq: each driven cycle pushes the expected post-edge outputs,
// a monitor pops and compares them just after the following rising edge.
module tb_rcu_pll_lock_seq;

    localparam int P = 4;
    localparam int L = 8;
    localparam int T = 32;
    localparam int R = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PWRUP  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_LOCKED = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       lost;
        logic [1:0] rty;
    } exp_t;

    logic       clk_i          = 1'b0;
    logic       rst_i          = 1'b1;
    logic       pll_en_i       = 1'b0;
    logic       pll_raw_lock_i = 1'b0;
    logic       pll_pd_o;
    logic       pll_rst_o;
    logic       pll_lock_o;
    logic       pll_fail_o;
    logic       lock_lost_o;
    logic [1:0] retry_cnt_o;
    logic [2:0] state_o;

    exp_t  sb[$];
    string tags[$];
    exp_t  cur;
    string cur_tag;
    int    n_vec = 0;
    int    n_err = 0;
    int    ph    = 0;

    always #5 clk_i = ~clk_i;

    rcu_pll_lock_seq #(
        .PWRUP_CYC      (P),
        .LOCK_STABLE_CYC(L),
        .TIMEOUT_CYC    (T),
        .MAX_RETRY      (R)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pll_en_i      (pll_en_i),
        .pll_raw_lock_i(pll_raw_lock_i),
        .pll_pd_o      (pll_pd_o),
        .pll_rst_o     (pll_rst_o),
        .pll_lock_o    (pll_lock_o),
        .pll_fail_o    (pll_fail_o),
        .lock_lost_o   (lock_lost_o),
        .retry_cnt_o   (retry_cnt_o),
        .state_o       (state_o)
    );

    task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next rising edge
    task automatic cyc(input logic r, input logic en, input logic raw,
                       input logic [2:0] st, input logic lost, input logic [1:0] rty,
                       input string tag);
        exp_t e;
        @(negedge clk_i);
        rst_i          = r;
        pll_en_i       = en;
        pll_raw_lock_i = raw;
        e.st   = st;
        e.lost = lost;
        e.rty  = rty;
        sb.push_back(e);
        tags.push_back(tag);
    endtask

    function automatic logic pat();
        logic v;
        v  = (ph % 8) != 7;
        ph = ph + 1;
        return v;
    endfunction

    always @(posedge clk_i) begin
        #1;
        if (sb.size() > 0) begin
            cur     = sb.pop_front();
            cur_tag = tags.pop_front();
            chk_eq({cur_tag, ".state"}, 8'(state_o), 8'(cur.st));
            chk_eq({cur_tag, ".pd"},    8'(pll_pd_o),
                   8'((cur.st == S_IDLE) || (cur.st == S_FAIL)));
            chk_eq({cur_tag, ".rst"},   8'(pll_rst_o),
                   8'((cur.st == S_IDLE) || (cur.st == S_PWRUP) || (cur.st == S_FAIL)));
            chk_eq({cur_tag, ".lock"},  8'(pll_lock_o), 8'(cur.st == S_LOCKED));
            chk_eq({cur_tag, ".fail"},  8'(pll_fail_o), 8'(cur.st == S_FAIL));
            chk_eq({cur_tag, ".lost"},  8'(lock_lost_o), 8'(cur.lost));
            chk_eq({cur_tag, ".retry"}, 8'(retry_cnt_o), 8'(cur.rty));
        end
    end

    initial begin
        cyc(1, 0, 0, S_IDLE, 0, 0, "reset");
        cyc(1, 0, 0, S_IDLE, 0, 0, "reset");

        // Clean power-up with raw lock steady high
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, S_IDLE, 0, 0, "t1_idle");
        for (int i = 0; i < P; i++) cyc(0, 1, 1, S_PWRUP, 0, 0, "t1_pwrup");
        for (int i = 0; i < L; i++) cyc(0, 1, 1, S_WAIT, 0, 0, "t1_wait");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, S_LOCKED, 0, 0, "t1_locked");

        // One-cycle raw lock glitch in LOCKED, then relock
        cyc(0, 1, 0, S_LOCKED, 0, 0, "t3_drop");
        cyc(0, 1, 1, S_LOCKED, 0, 0, "t3_sync");
        cyc(0, 1, 1, S_WAIT, 1, 0, "t3_lost");
        for (int i = 1; i < L; i++) cyc(0, 1, 1, S_WAIT, 0, 0, "t3_wait");
        cyc(0, 1, 1, S_LOCKED, 0, 0, "t3_relock");

        // Stable count reaches its last value on the timeout cycle
        cyc(0, 1, 0, S_LOCKED, 0, 0, "t4_drop");
        cyc(0, 1, 0, S_LOCKED, 0, 0, "t4_sync");
        cyc(0, 1, 0, S_WAIT, 1, 0, "t4_lost");
        for (int j = 1; j <= T; j++)
            cyc(0, 1, logic'(j >= T - L - 1), (j == T) ? S_LOCKED : S_WAIT, 0, 0, "t4");
        cyc(0, 1, 1, S_LOCKED, 0, 0, "t4_hold");

        cyc(0, 0, 1, S_IDLE, 0, 0, "en_off_locked");

        // Glitchy lock never qualifies: two retries then FAIL
        for (int r = 0; r <= R; r++) begin
            for (int i = 0; i < P; i++) cyc(0, 1, pat(), S_PWRUP, 0, 2'(r), "t2_pwrup");
            for (int i = 0; i < T; i++) cyc(0, 1, pat(), S_WAIT, 0, 2'(r), "t2_wait");
        end
        for (int i = 0; i < 3; i++) cyc(0, 1, pat(), S_FAIL, 0, 2'(R), "t2_fail");

        // Leave FAIL via enable drop, then a fresh sequence with one retry
        cyc(0, 0, 0, S_IDLE, 0, 0, "t5_idle");
        for (int i = 0; i < P; i++) cyc(0, 1, 0, S_PWRUP, 0, 0, "t5_pwrup");
        for (int i = 0; i < T; i++) cyc(0, 1, 0, S_WAIT, 0, 0, "t5_wait");
        for (int i = 0; i < P; i++) cyc(0, 1, 0, S_PWRUP, 0, 1, "t5_pwrup2");
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, S_WAIT, 0, 1, "t5_wait2");

        // Synchronous reset mid WAIT_LOCK
        cyc(1, 1, 0, S_IDLE, 0, 0, "t6_rst");
        cyc(0, 1, 0, S_PWRUP, 0, 0, "t6_after");
        cyc(0, 0, 0, S_IDLE, 0, 0, "t6_off");

        @(posedge clk_i);
        #3;
        chk_eq("drain", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
